// File: rtl/led_chaser_pkg.sv
// Shared definitions for the LED chaser: default width, pattern codes,
// FSM state encoding and the starting image of each pattern.
package led_chaser_pkg;

   localparam int W_DEFAULT = 8;

   localparam logic [1:0] PAT_ROT_L  = 2'b00;
   localparam logic [1:0] PAT_ROT_R  = 2'b01;
   localparam logic [1:0] PAT_BOUNCE = 2'b10;
   localparam logic [1:0] PAT_FILL   = 2'b11;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Starting images are width independent, so they are described by which
   // end (if any) of the LED bar is lit; the top module expands them to W bits.
   typedef enum logic [1:0] {
      SEED_NONE = 2'b00,
      SEED_LSB  = 2'b01,
      SEED_MSB  = 2'b10
   } seed_e;

   localparam seed_e INIT_ROT_L  = SEED_LSB;
   localparam seed_e INIT_ROT_R  = SEED_MSB;
   localparam seed_e INIT_BOUNCE = SEED_LSB;
   localparam seed_e INIT_FILL   = SEED_NONE;

endpackage

// File: rtl/led_chaser_ctrl_sync_ff.sv
// Multi-stage flip-flop synchronizer used to bring the board switches into
// the clock domain before any decision is made on them.
module sync_ff #(
   parameter int WIDTH  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stageQ [STAGES];

   // Shift the raw input through the chain; the whole chain clears on reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < STAGES; i++) begin
            stageQ[i] <= '0;
         end
      end else begin
         stageQ[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            stageQ[i] <= stageQ[i-1];
         end
      end
   end

   assign q_o = stageQ[STAGES-1];

endmodule

// File: rtl/led_chaser_ctrl.sv
// LED chaser sequencer: paces an 8-LED pattern from one of four divider
// square waves and switches between rotate, bounce and fill patterns.
module led_chaser_ctrl
   import led_chaser_pkg::*;
#(
   parameter int W           = W_DEFAULT,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [3:0]   rate_in,
   input  logic [3:0]   sw,
   output logic [W-1:0] led,
   output logic         step
);

   localparam logic [W-1:0] LED_LSB = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] LED_MSB = {1'b1, {(W-1){1'b0}}};

   logic [3:0]   swSync;
   logic [1:0]   sel;
   logic         cur;
   logic         tick;
   logic         prevQ;
   logic [1:0]   selPrevQ;
   state_e       stateQ;
   logic [W-1:0] ledQ;
   logic         stepQ;
   logic [1:0]   patQ;
   logic         dirQ;
   logic         phaseQ;
   logic [W-1:0] ledD;
   logic         dirD;
   logic         phaseD;
   logic [W-1:0] initLed;
   seed_e        seed;

   sync_ff #(
      .WIDTH  (4),
      .STAGES (SYNC_STAGES)
   ) swSyncInst (
      .clk   (clk),
      .reset (reset),
      .d_i   (sw),
      .q_o   (swSync)
   );

   // Pick the paced divider bit and turn its rising edge into a tick; a tick
   // is suppressed in the cycle the speed selection changes, because the
   // previous sample belongs to a different divider output.
   always_comb begin
      sel  = swSync[1:0];
      cur  = rate_in[sel];
      tick = cur & ~prevQ & (sel == selPrevQ);
   end

   // Remember last cycle's selected level and selection for edge detection.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prevQ    <= 1'b0;
         selPrevQ <= 2'b00;
      end else begin
         prevQ    <= cur;
         selPrevQ <= sel;
      end
   end

   // Expand the current pattern's seed into the starting LED image.
   always_comb begin
      seed = SEED_NONE;
      case (patQ)
         PAT_ROT_L:  seed = INIT_ROT_L;
         PAT_ROT_R:  seed = INIT_ROT_R;
         PAT_BOUNCE: seed = INIT_BOUNCE;
         default:    seed = INIT_FILL;
      endcase
      case (seed)
         SEED_LSB: initLed = LED_LSB;
         SEED_MSB: initLed = LED_MSB;
         default:  initLed = '0;
      endcase
   end

   // Compute the next LED image, bounce direction and fill phase for one step.
   always_comb begin
      ledD   = ledQ;
      dirD   = dirQ;
      phaseD = phaseQ;
      case (patQ)
         PAT_ROT_L: ledD = {ledQ[W-2:0], ledQ[W-1]};
         PAT_ROT_R: ledD = {ledQ[0], ledQ[W-1:1]};
         PAT_BOUNCE: begin
            if (!dirQ) begin
               if (ledQ[W-1]) begin
                  ledD = ledQ >> 1;
                  dirD = 1'b1;
               end else begin
                  ledD = ledQ << 1;
               end
            end else begin
               if (ledQ[0]) begin
                  ledD = ledQ << 1;
                  dirD = 1'b0;
               end else begin
                  ledD = ledQ >> 1;
               end
            end
         end
         default: begin
            if (!phaseQ) begin
               ledD = {ledQ[W-2:0], 1'b1};
               if (ledD == '1) begin
                  phaseD = 1'b1;
               end
            end else begin
               ledD = {ledQ[W-2:0], 1'b0};
               if (ledD == '0) begin
                  phaseD = 1'b0;
               end
            end
         end
      endcase
   end

   // Sequencer: LOAD seeds the pattern, RUN advances on ticks and reloads
   // when the pattern switches change (a pattern change outranks a tick).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stateQ <= ST_LOAD;
         ledQ   <= '0;
         stepQ  <= 1'b0;
         patQ   <= PAT_ROT_L;
         dirQ   <= 1'b0;
         phaseQ <= 1'b0;
      end else begin
         case (stateQ)
            ST_LOAD: begin
               ledQ   <= initLed;
               dirQ   <= 1'b0;
               phaseQ <= 1'b0;
               stepQ  <= 1'b0;
               stateQ <= ST_RUN;
            end
            default: begin
               if (swSync[3:2] != patQ) begin
                  patQ   <= swSync[3:2];
                  stepQ  <= 1'b0;
                  stateQ <= ST_LOAD;
               end else if (tick) begin
                  ledQ   <= ledD;
                  dirQ   <= dirD;
                  phaseQ <= phaseD;
                  stepQ  <= 1'b1;
               end else begin
                  stepQ  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign led  = ledQ;
   assign step = stepQ;

endmodule

// File: tb/tb_led_chaser_ctrl.sv
// Directed bench for the LED chaser: walks every pattern, speed switching,
// and the pattern-change and reset collisions with hand-computed values.
module tb_led_chaser_ctrl;

   logic       clk;
   logic       reset;
   logic [3:0] rate_in;
   logic [3:0] sw;
   logic [7:0] led;
   logic       step;

   int checks   = 0;
   int failures = 0;

   logic [7:0] rotLExp   [0:7];
   logic [7:0] rotRExp   [0:7];
   logic [7:0] bounceExp [0:14];
   logic [7:0] fillExp   [0:16];

   led_chaser_ctrl #(
      .W           (8),
      .SYNC_STAGES (2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .rate_in (rate_in),
      .sw      (sw),
      .led     (led),
      .step    (step)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic stepClock();
      @(posedge clk);
      #1;
   endtask

   task automatic waitCycles(input int n);
      for (int i = 0; i < n; i++) begin
         stepClock();
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] expLed, input logic expStep);
      checks++;
      assert (led === expLed) else begin
         failures++;
         $error("[TB] FAIL %s led observed=%h expected=%h", tag, led, expLed);
      end
      checks++;
      assert (step === expStep) else begin
         failures++;
         $error("[TB] FAIL %s step observed=%b expected=%b", tag, step, expStep);
      end
   endtask

   // One full pulse on rate_in[idx]; the LED check lands on the cycle after
   // the rising edge is seen.
   task automatic applyStimulus(input int idx, input string tag, input logic [7:0] expLed, input logic expStep);
      rate_in[idx] = 1'b1;
      stepClock();
      checkOutput(tag, expLed, expStep);
      rate_in[idx] = 1'b0;
      stepClock();
   endtask

   // Directed sequence through all scenarios.
   initial begin
      rotLExp   = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
      rotRExp   = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};
      bounceExp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                    8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
      fillExp   = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};

      reset   = 1'b0;
      sw      = 4'b0000;
      rate_in = 4'b0000;
      #3;
      checkOutput("reset", 8'h00, 1'b0);
      waitCycles(2);
      checkOutput("reset_held", 8'h00, 1'b0);

      // Release reset: first cycle is LOAD of ROT_L.
      reset = 1'b1;
      stepClock();
      checkOutput("load_rotl", 8'h01, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, "rotl", rotLExp[i], 1'b1);
      end

      // ROT_R: sync (2) + detect + LOAD.
      sw = 4'b0100;
      waitCycles(4);
      checkOutput("load_rotr", 8'h80, 1'b0);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(0, "rotr", rotRExp[i], 1'b1);
      end
      for (int i = 1; i < 4; i++) begin
         applyStimulus(i, "unselected_rate", 8'h80, 1'b0);
      end

      // BOUNCE.
      sw = 4'b1000;
      waitCycles(4);
      checkOutput("load_bounce", 8'h01, 1'b0);
      for (int i = 0; i < 15; i++) begin
         applyStimulus(0, "bounce", bounceExp[i], 1'b1);
      end

      // FILL.
      sw = 4'b1100;
      waitCycles(4);
      checkOutput("load_fill", 8'h00, 1'b0);
      for (int i = 0; i < 17; i++) begin
         applyStimulus(0, "fill", fillExp[i], 1'b1);
      end

      // Speed switch 00 -> 11 while rate_in[3] already high.
      rate_in[3] = 1'b1;
      stepClock();
      checkOutput("slow_high_unselected", 8'h01, 1'b0);
      sw = 4'b1111;
      waitCycles(2);
      rate_in[0] = 1'b1;
      stepClock();
      checkOutput("speed_switch_no_step", 8'h01, 1'b0);
      stepClock();
      checkOutput("speed_switch_hold", 8'h01, 1'b0);
      rate_in[0] = 1'b0;
      stepClock();
      applyStimulus(0, "fast_ignored", 8'h01, 1'b0);
      rate_in[3] = 1'b0;
      stepClock();
      rate_in[3] = 1'b1;
      stepClock();
      checkOutput("slow_step", 8'h03, 1'b1);

      // Pattern change collides with a tick: change wins, then LOAD.
      rate_in[3] = 1'b0;
      stepClock();
      sw = 4'b0111;
      waitCycles(2);
      rate_in[3] = 1'b1;
      stepClock();
      checkOutput("collide_change", 8'h03, 1'b0);
      stepClock();
      checkOutput("collide_load", 8'h80, 1'b0);
      stepClock();
      checkOutput("collide_after", 8'h80, 1'b0);

      // Reset in the middle of BOUNCE, asynchronous.
      rate_in[3] = 1'b0;
      sw = 4'b1011;
      waitCycles(4);
      checkOutput("load_bounce2", 8'h01, 1'b0);
      rate_in[3] = 1'b1;
      stepClock();
      checkOutput("bounce2_step", 8'h02, 1'b1);
      reset = 1'b0;
      #1;
      checkOutput("async_reset", 8'h00, 1'b0);
      stepClock();
      reset = 1'b1;
      stepClock();
      checkOutput("reset_release_load", 8'h01, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
